// File: rtl/daq_raw_framer_p.sv
// rtl/daq_raw_framer_p.sv - Raw-hit DAQ framer: hit ring, L1A descriptor FIFO, framed word stream
// Ports: clk, hard_rst (sync, active-high); hits/bxn sampled every cycle;
//        l1a pushes a readout descriptor; l1a_delay/tbins/zero_suppress configure readout;
//        daq_word/daq_valid/daq_last/daq_ready form the output stream;
//        l1a_fifo_full, l1a_drop_count and busy report status.
module daq_raw_framer_p #(
  parameter int NLY       = 6,
  parameter int NWG       = 64,
  parameter int ADDR_W    = 8,
  parameter int L1A_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 hard_rst,
  input  logic [NLY*NWG-1:0]   hits,
  input  logic [11:0]          bxn,
  input  logic                 l1a,
  input  logic [7:0]           l1a_delay,
  input  logic [4:0]           tbins,
  input  logic                 zero_suppress,
  input  logic                 daq_ready,
  output logic [15:0]          daq_word,
  output logic                 daq_valid,
  output logic                 daq_last,
  output logic                 l1a_fifo_full,
  output logic [7:0]           l1a_drop_count,
  output logic                 busy
);
  localparam int W  = (NWG + 11) / 12;
  localparam int HW = NLY * NWG;
  localparam int LW = (NLY > 1) ? $clog2(NLY) : 1;
  localparam int JW = (W > 1) ? $clog2(W) : 1;
  localparam int FW = (L1A_DEPTH > 1) ? $clog2(L1A_DEPTH) : 1;
  localparam int DW = ADDR_W + 24;

  // Hit history ring; no reset needed on the storage itself.
  logic [HW-1:0]     ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [HW-1:0]     rdata;

  always_ff @(posedge clk) begin
    ram[wr_ptr] <= hits;
    rdata       <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (hard_rst) wr_ptr <= '0;
    else          wr_ptr <= wr_ptr + ADDR_W'(1);
  end

  // Descriptor FIFO: {start, bxn, l1a_count}
  logic [DW-1:0] fifo_mem [0:L1A_DEPTH-1];
  logic [FW-1:0] fifo_wp, fifo_rp;
  logic [FW:0]   fifo_cnt;
  logic [11:0]   l1a_count;
  logic          fifo_empty, push, pop, drop;
  logic [DW-1:0] fifo_head;

  assign fifo_empty    = (fifo_cnt == '0);
  assign l1a_fifo_full = (fifo_cnt == (FW+1)'(L1A_DEPTH));
  // A simultaneous pop frees the slot the push needs, so the push is accepted.
  assign push          = l1a && (!l1a_fifo_full || pop);
  assign drop          = l1a && !push;
  assign fifo_head     = fifo_mem[fifo_rp];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp] <= {wr_ptr - ADDR_W'(l1a_delay), bxn, l1a_count};
  end

  always_ff @(posedge clk) begin
    if (hard_rst) begin
      fifo_wp        <= '0;
      fifo_rp        <= '0;
      fifo_cnt       <= '0;
      l1a_count      <= '0;
      l1a_drop_count <= '0;
    end else begin
      if (push) begin
        fifo_wp   <= fifo_wp + FW'(1);
        l1a_count <= l1a_count + 12'd1;
      end
      if (pop) fifo_rp <= fifo_rp + FW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop && l1a_drop_count != 8'hFF) l1a_drop_count <= l1a_drop_count + 8'd1;
    end
  end

  // Framer FSM. FETCH is the one-cycle RAM read at the start of each time bin.
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_DATA, S_PAD, S_TRL} state_t;
  state_t state, state_n;

  logic [1:0]        hdr_idx, hdr_idx_n;
  logic [4:0]        bin, bin_n, tb_q, tb_n;
  logic [LW-1:0]     lay, lay_n;
  logic [JW-1:0]     wj, wj_n;
  logic [11:0]       nwords, nwords_n, bxn_q, bxn_n, cnt_q, cnt_n;
  logic              zs_q, zs_n;
  logic [ADDR_W-1:0] start_q, start_n;
  logic [15:0]       word_n, w;
  logic              valid_n, last_n, emit, lst, lay_done, bin_done, adv;
  logic [NWG-1:0]    lay_bits;
  logic [W*12-1:0]   padded;
  logic [11:0]       seg;

  // The whole pipeline advances only when the output register is free or draining,
  // which keeps daq_word/daq_valid/daq_last frozen during a stall.
  assign adv     = !daq_valid || daq_ready;
  assign rd_addr = start_q + ADDR_W'(bin);
  assign busy    = (state != S_IDLE) || daq_valid || !fifo_empty;

  always_comb begin
    lay_bits = '0;
    for (int l = 0; l < NLY; l++)
      if (LW'(l) == lay) lay_bits = rdata[l*NWG +: NWG];
    padded = (W*12)'(lay_bits);
    seg    = '0;
    for (int j = 0; j < W; j++)
      if (JW'(j) == wj) seg = padded[j*12 +: 12];
  end

  always_comb begin
    state_n   = state;
    hdr_idx_n = hdr_idx;
    bin_n     = bin;
    tb_n      = tb_q;
    lay_n     = lay;
    wj_n      = wj;
    nwords_n  = nwords;
    bxn_n     = bxn_q;
    cnt_n     = cnt_q;
    zs_n      = zs_q;
    start_n   = start_q;
    word_n    = daq_word;
    valid_n   = daq_valid;
    last_n    = daq_last;
    pop       = 1'b0;
    emit      = 1'b0;
    lst       = 1'b0;
    w         = 16'h0000;
    lay_done  = 1'b0;
    bin_done  = 1'b0;
    if (adv) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
      case (state)
        S_IDLE: begin
          // Frames are only committed once downstream can take words.
          if (!fifo_empty && daq_ready) begin
            pop       = 1'b1;
            start_n   = fifo_head[DW-1 -: ADDR_W];
            bxn_n     = fifo_head[23:12];
            cnt_n     = fifo_head[11:0];
            tb_n      = tbins;
            zs_n      = zero_suppress;
            nwords_n  = '0;
            hdr_idx_n = '0;
            bin_n     = '0;
            state_n   = S_HDR;
          end
        end
        S_HDR: begin
          emit = 1'b1;
          case (hdr_idx)
            2'd0:    w = 16'hDB0A;
            2'd1:    w = {4'hD, bxn_q};
            2'd2:    w = {4'hD, cnt_q};
            default: w = {3'b000, zs_q, 7'b0000000, tb_q};
          endcase
          hdr_idx_n = hdr_idx + 2'd1;
          if (hdr_idx == 2'd3) state_n = (tb_q == 5'd0) ? S_PAD : S_FETCH;
        end
        S_FETCH: begin
          lay_n   = '0;
          wj_n    = '0;
          state_n = S_DATA;
        end
        S_DATA: begin
          emit = 1'b1;
          if (zs_q && rdata == '0) begin
            w        = 16'h2000;
            bin_done = 1'b1;
          end else if (zs_q && lay_bits == '0) begin
            w        = 16'h1000;
            lay_done = 1'b1;
          end else begin
            w = {4'h0, seg};
            if (wj == JW'(W-1)) lay_done = 1'b1;
            else                wj_n     = wj + JW'(1);
          end
          if (lay_done) begin
            wj_n = '0;
            if (lay == LW'(NLY-1)) bin_done = 1'b1;
            else                   lay_n    = lay + LW'(1);
          end
          if (bin_done) begin
            bin_n   = bin + 5'd1;
            state_n = (bin + 5'd1 == tb_q) ? S_PAD : S_FETCH;
          end
        end
        S_PAD: begin
          emit = 1'b1;
          // Pad so the frame length including both trailer words is a multiple of 4.
          if (nwords[1:0] + 2'd2 != 2'd0) w = 16'h3000;
          else begin
            w       = 16'hDE0D;
            state_n = S_TRL;
          end
        end
        S_TRL: begin
          emit    = 1'b1;
          lst     = 1'b1;
          w       = {4'hE, nwords + 12'd1};
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
      if (emit) begin
        word_n   = w;
        valid_n  = 1'b1;
        last_n   = lst;
        nwords_n = nwords + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state     <= S_IDLE;
      hdr_idx   <= '0;
      bin       <= '0;
      tb_q      <= '0;
      lay       <= '0;
      wj        <= '0;
      nwords    <= '0;
      bxn_q     <= '0;
      cnt_q     <= '0;
      zs_q      <= 1'b0;
      start_q   <= '0;
      daq_word  <= '0;
      daq_valid <= 1'b0;
      daq_last  <= 1'b0;
    end else begin
      state     <= state_n;
      hdr_idx   <= hdr_idx_n;
      bin       <= bin_n;
      tb_q      <= tb_n;
      lay       <= lay_n;
      wj        <= wj_n;
      nwords    <= nwords_n;
      bxn_q     <= bxn_n;
      cnt_q     <= cnt_n;
      zs_q      <= zs_n;
      start_q   <= start_n;
      daq_word  <= word_n;
      daq_valid <= valid_n;
      daq_last  <= last_n;
    end
  end
endmodule

// File: tb/tb_daq_raw_framer_p.sv
// tb/tb_daq_raw_framer_p.sv - Scoreboard bench for daq_raw_framer_p
module tb_daq_raw_framer_p;
  localparam int NLY = 6;
  localparam int NWG = 64;
  localparam int HW  = NLY * NWG;
  localparam int HD  = 8192;

  logic          clk = 1'b0;
  logic          hard_rst;
  logic [HW-1:0] hits;
  logic [11:0]   bxn;
  logic          l1a;
  logic [7:0]    l1a_delay;
  logic [4:0]    tbins;
  logic          zero_suppress;
  logic          daq_ready;
  logic [15:0]   daq_word;
  logic          daq_valid;
  logic          daq_last;
  logic          l1a_fifo_full;
  logic [7:0]    l1a_drop_count;
  logic          busy;

  always #5 clk = ~clk;

  daq_raw_framer_p #(.NLY(NLY), .NWG(NWG), .ADDR_W(8), .L1A_DEPTH(8)) dut (
    .clk(clk), .hard_rst(hard_rst), .hits(hits), .bxn(bxn), .l1a(l1a),
    .l1a_delay(l1a_delay), .tbins(tbins), .zero_suppress(zero_suppress),
    .daq_ready(daq_ready), .daq_word(daq_word), .daq_valid(daq_valid),
    .daq_last(daq_last), .l1a_fifo_full(l1a_fifo_full),
    .l1a_drop_count(l1a_drop_count), .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct { logic [15:0] w; logic l; } ent_t;
  ent_t exp_q[$];

  int            cyc = 0;
  logic [HW-1:0] hist [0:HD-1];
  always @(posedge clk) begin
    hist[cyc % HD] <= hits;
    cyc            <= cyc + 1;
  end

  function automatic logic [HW-1:0] pat(input int c);
    logic [HW-1:0] v;
    for (int k = 0; k < HW/32; k++)
      v[k*32 +: 32] = 32'(c) * 32'h9E3779B1 + 32'(k) * 32'h01010101;
    return v;
  endfunction

  // Sparse pattern: some layers empty, every fifth bin entirely empty.
  function automatic logic [HW-1:0] sparse(input int c);
    logic [HW-1:0] v;
    v = pat(c);
    for (int l = 0; l < NLY; l++)
      if (((c + l) % 3) != 0) v[l*NWG +: NWG] = '0;
    if ((c % 5) == 0) v = '0;
    return v;
  endfunction

  int hmode = 0;
  bit rr    = 0;
  int cnt_exp = 0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (rr) daq_ready = ($urandom % 2) == 1;
    if (hmode == 0) hits = pat(cyc);
    else if (hmode == 2) hits = sparse(cyc);
  endtask

  task automatic build_frame(input int lc, input logic [11:0] bx, input logic [11:0] cn);
    logic [15:0]    w[$];
    logic [HW-1:0]  row;
    logic [NWG-1:0] ly;
    int             n;
    ent_t           e;
    w.push_back(16'hDB0A);
    w.push_back({4'hD, bx});
    w.push_back({4'hD, cn});
    w.push_back({3'b000, zero_suppress, 7'b0000000, tbins});
    for (int b = 0; b < int'(tbins); b++) begin
      row = hist[(lc - int'(l1a_delay) + b) % HD];
      if (zero_suppress && row == '0) w.push_back(16'h2000);
      else begin
        for (int l = 0; l < NLY; l++) begin
          ly = row[l*NWG +: NWG];
          if (zero_suppress && ly == '0) w.push_back(16'h1000);
          else
            for (int j = 0; j < (NWG + 11) / 12; j++)
              w.push_back({4'h0, 12'(ly >> (12 * j))});
        end
      end
    end
    while (((w.size() + 2) % 4) != 0) w.push_back(16'h3000);
    w.push_back(16'hDE0D);
    n = w.size() + 1;
    w.push_back({4'hE, 12'(n)});
    for (int i = 0; i < w.size(); i++) begin
      e.w = w[i];
      e.l = (i == w.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_l1a();
    l1a = 1'b1;
    bxn = 12'($urandom);
    build_frame(cyc, bxn, 12'(cnt_exp));
    cnt_exp++;
    tick();
    l1a = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      tick();
      t++;
    end
    check_eq("idle_timeout", {31'b0, busy}, 32'd0);
    check_eq("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    hard_rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    hard_rst = 1'b0;
    cnt_exp  = 0;
  endtask

  // Output monitor: compares each transferred word and checks stall stability.
  int          n_xfer = 0;
  bit          pstall = 0;
  logic [15:0] pw;
  logic        pl;
  ent_t        me;
  always @(negedge clk) begin
    if (hard_rst) pstall = 0;
    else begin
      if (pstall) begin
        check_eq("stall_valid", {31'b0, daq_valid}, 32'd1);
        check_eq("stall_word", {16'b0, daq_word}, {16'b0, pw});
        check_eq("stall_last", {31'b0, daq_last}, {31'b0, pl});
      end
      if (daq_valid && daq_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) check_eq("extra_word", 32'd0, 32'd1);
        else begin
          me = exp_q.pop_front();
          check_eq("word", {16'b0, daq_word}, {16'b0, me.w});
          check_eq("last", {31'b0, daq_last}, {31'b0, me.l});
        end
      end
      pstall = daq_valid && !daq_ready;
      pw     = daq_word;
      pl     = daq_last;
    end
  end

  initial begin
    int t;
    int target;
    hard_rst      = 1'b1;
    hits          = pat(0);
    bxn           = '0;
    l1a           = 1'b0;
    l1a_delay     = 8'd4;
    tbins         = 5'd1;
    zero_suppress = 1'b0;
    daq_ready     = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", {31'b0, daq_valid}, 32'd0);
    check_eq("rst_last", {31'b0, daq_last}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_full", {31'b0, l1a_fifo_full}, 32'd0);
    check_eq("rst_drop", {24'b0, l1a_drop_count}, 32'd0);
    hard_rst = 1'b0;
    repeat (12) tick();

    // Ramp hits, no suppression, one bin.
    do_l1a();
    wait_idle();

    // All-zero hits with suppression, two bins.
    hmode = 1; hits = '0; zero_suppress = 1'b1; tbins = 5'd2;
    repeat (6) tick();
    do_l1a();
    wait_idle();

    // Single hit on layer 2 wire 13.
    hits = '0; hits[2*NWG + 13] = 1'b1; tbins = 5'd1;
    repeat (6) tick();
    do_l1a();
    wait_idle();

    // Random backpressure across several configurations.
    rr = 1; hmode = 0; zero_suppress = 1'b0; tbins = 5'd1; l1a_delay = 8'd4;
    repeat (6) tick();
    do_l1a();
    wait_idle();
    hmode = 2; zero_suppress = 1'b1; tbins = 5'd3; l1a_delay = 8'd6;
    repeat (8) tick();
    do_l1a();
    do_l1a();
    wait_idle();
    hmode = 0; zero_suppress = 1'b0; tbins = 5'd0; l1a_delay = 8'd2;
    do_l1a();
    wait_idle();
    rr = 0; daq_ready = 1'b1;

    // FIFO overflow with downstream blocked.
    do_reset();
    tbins = 5'd0; zero_suppress = 1'b0; daq_ready = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      l1a = 1'b1;
      bxn = 12'(i * 16 + 3);
      if (i < 8) begin
        build_frame(cyc, bxn, 12'(cnt_exp));
        cnt_exp++;
      end
      tick();
      if (i == 6) check_eq("full_after_7", {31'b0, l1a_fifo_full}, 32'd0);
      if (i == 7) check_eq("full_after_8", {31'b0, l1a_fifo_full}, 32'd1);
    end
    l1a = 1'b0;
    check_eq("drop_count", {24'b0, l1a_drop_count}, 32'd2);
    check_eq("busy_blocked", {31'b0, busy}, 32'd1);
    daq_ready = 1'b1;
    wait_idle();
    check_eq("drop_hold", {24'b0, l1a_drop_count}, 32'd2);

    // Reset in the middle of a data phase.
    hmode = 0; tbins = 5'd2; l1a_delay = 8'd4;
    repeat (12) tick();
    target = n_xfer + 10;
    do_l1a();
    t = 0;
    while (n_xfer < target && t < 500) begin
      tick();
      t++;
    end
    check_eq("xfer_timeout", {31'b0, n_xfer >= target}, 32'd1);
    hard_rst = 1'b1;
    exp_q.delete();
    tick();
    check_eq("midrst_valid", {31'b0, daq_valid}, 32'd0);
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    check_eq("midrst_drop", {24'b0, l1a_drop_count}, 32'd0);
    check_eq("midrst_full", {31'b0, l1a_fifo_full}, 32'd0);
    hard_rst = 1'b0;
    cnt_exp  = 0;
    repeat (12) tick();
    do_l1a();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
